seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
Parametrised multi-cycle integer divider, the successor to the fixed 32-bit repeated-subtraction divider in the ALU.
- Radix-2 restoring shift-subtract core; latency is fixed at WIDTH+1 cycles regardless of operand values.
- Supports signed and unsigned modes, with an explicit start/done handshake and divide-by-zero flag.
- Sits beside the ALU datapath; the ALU control FSM raises in_en and waits for out_en.

Parameters:
WIDTH, 32, operand, quotient and remainder width (>= 4).
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_en  in  1  start request; accepted only when busy=0
is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with in_en
a  in  WIDTH  dividend; sampled with in_en
b  in  WIDTH  divisor; sampled with in_en
busy  out  1  high from the accepting edge until the edge that raises out_en
out_en  out  1  one-cycle done pulse; q, r, error are valid while it is high and held afterwards
error  out  1  divide-by-zero flag for the last operation
q  out  WIDTH  quotient, truncated toward zero
r  out  WIDTH  remainder; sign follows the dividend; |r| < |b|

Behaviour:
- Clock is clk; reset is synchronous and active-high (rst). Already decided.
- Reset: state=IDLE; busy, out_en, error = 0; q, r, counter and internal registers = 0.
- Reset mid-operation aborts immediately. No out_en is produced for the aborted operation.
- State IDLE:
  - If in_en=1, capture the operand magnitudes: |a| and |b| when is_signed=1, raw values otherwise.
  - Capture neg_q = is_signed & (a[MSB]^b[MSB]) and neg_r = is_signed & a[MSB].
  - Clear the partial remainder and counter, set busy=1.
  - Go to ZERO if b==0, else go to CALC.
- State CALC: one iteration per cycle.
  - Shift {rem, quo} left by 1 and bring in the dividend MSB.
  - Compute trial = rem - |b| at WIDTH+1 bits.
  - If trial is non-negative, rem = trial and quo LSB = 1.
  - After WIDTH iterations go to FIX.
- State FIX:
  - Apply signs: q = neg_q ? -quo : quo; r = neg_r ? -rem : rem.
  - Set out_en=1 and error=0, clear busy, return to IDLE.
- State ZERO: q = all ones, r = a (raw), error=1, out_en=1, busy=0; return to IDLE.
- Latency, counting the accepting edge as E0:
  - Normal operation: out_en is high in the cycle after edge E(WIDTH+1).
  - Divide by zero: out_en is high in the cycle after E1.
- Boundary cases:
  - Signed MIN / -1: q = MIN (wraps), r = 0, error = 0. No special casing.
  - |MIN| is handled as the unsigned value 2^(WIDTH-1); the magnitude path is WIDTH bits unsigned, with a WIDTH+1-bit trial subtract.
  - Operand changes on a, b, is_signed while busy=1 are ignored; no restart.
  - in_en while busy=1 is ignored (not queued).
  - in_en in the same cycle as out_en=1 is accepted, because state is IDLE. Back-to-back throughput is one result per WIDTH+2 cycles.
  - rst and in_en together: rst wins and nothing is accepted.
  - q, r and error hold their values until the next completion. A new start does not clear them.

Decomposition:
- Shared package div_pkg holds:
  - state enum div_state_t {IDLE, CALC, FIX, ZERO}
  - localparam defining the divide-by-zero quotient (all ones)
- One natural sub-module, div_step: a combinational single restoring iteration.
  - Inputs: rem, next dividend bit, |b|.
  - Outputs: new rem, quotient bit.
  - Parametrised by WIDTH; replaces the hard-wired fulladder32 dependency.

Test Plan:
1. WIDTH=32, unsigned, a=100, b=7 -> out_en in cycle E33, q=14, r=2, error=0; busy high for exactly 33 cycles.
2. Signed quadrants, each giving error=0:
   - a=-7, b=2 -> q=-3, r=-1
   - a=7, b=-2 -> q=-3, r=1
   - a=-7, b=-2 -> q=3, r=-1
   - unsigned a=0xFFFFFFF9, b=2 -> q=0x7FFFFFFC, r=1
3. Divide by zero: a=55, b=0, either mode -> out_en in cycle E1, error=1, q=0xFFFFFFFF, r=55. The next valid division clears error.
4. Signed overflow: a=0x80000000, b=0xFFFFFFFF -> q=0x80000000, r=0, error=0. Unsigned a=0xFFFFFFFF, b=1 -> q=0xFFFFFFFF, r=0.
5. Handshake:
   - in_en pulsed at E10 during busy, with a and b changed -> ignored; the original result is returned.
   - in_en held high through out_en -> the second op starts with no idle gap.
6. rst asserted at iteration 15 -> all outputs 0 on the next edge and no out_en. Rerunning at WIDTH=8 with a=200, b=13 unsigned -> out_en in cycle E9, q=15, r=5.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
package div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      ZERO
   } div_state_t;

   // Fill bit for the divide-by-zero quotient; replicated to WIDTH by the user.
   localparam logic DIV_ZERO_Q_BIT = 1'b1;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract iteration
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             next_bit,
   input  logic [WIDTH-1:0] b_mag,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   assign shifted = {rem, next_bit};
   assign trial   = shifted - {1'b0, b_mag};

   // rem < b_mag on entry, so a non-negative trial always fits in WIDTH bits
   // and a negative one always sets the top bit.
   assign q_bit    = ~trial[WIDTH];
   assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle signed/unsigned radix-2 restoring divider
module seq_divider
   import div_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_en,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             out_en,
   output logic             error,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   div_state_t       state, state_next;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH-1:0] a_raw;
   logic [CNT_W-1:0] cnt;
   logic             neg_q;
   logic             neg_r;

   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic [WIDTH-1:0] rem_next;
   logic             q_bit;

   // |MIN| wraps back to MIN, which is exactly 2^(WIDTH-1) read as unsigned.
   assign a_abs = (is_signed && a[WIDTH-1]) ? -a : a;
   assign b_abs = (is_signed && b[WIDTH-1]) ? -b : b;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .next_bit (quo[WIDTH-1]),
      .b_mag    (b_mag),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (in_en) state_next = (b == '0) ? ZERO : CALC;
         CALC: if (cnt == LAST_ITER) state_next = FIX;
         FIX:  state_next = IDLE;
         ZERO: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem    <= '0;
         quo    <= '0;
         b_mag  <= '0;
         a_raw  <= '0;
         cnt    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         busy   <= 1'b0;
         out_en <= 1'b0;
         error  <= 1'b0;
         q      <= '0;
         r      <= '0;
      end else begin
         out_en <= 1'b0;
         case (state)
            IDLE: begin
               if (in_en) begin
                  rem   <= '0;
                  cnt   <= '0;
                  quo   <= a_abs;
                  b_mag <= b_abs;
                  a_raw <= a;
                  neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r <= is_signed & a[WIDTH-1];
                  busy  <= 1'b1;
               end
            end
            CALC: begin
               // quo shifts dividend bits out the top while quotient bits enter below
               rem <= rem_next;
               quo <= {quo[WIDTH-2:0], q_bit};
               cnt <= cnt + CNT_W'(1);
            end
            FIX: begin
               q      <= neg_q ? -quo : quo;
               r      <= neg_r ? -rem : rem;
               error  <= 1'b0;
               out_en <= 1'b1;
               busy   <= 1'b0;
            end
            ZERO: begin
               q      <= {WIDTH{DIV_ZERO_Q_BIT}};
               r      <= a_raw;
               error  <= 1'b1;
               out_en <= 1'b1;
               busy   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized scoreboard bench for seq_divider at WIDTH 32 and 8
module tb_seq_divider;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst32, in_en32, sg32;
   logic [31:0] a32, b32, q32o, r32o;
   logic        busy32, out_en32, err32;

   logic        rst8, in_en8, sg8;
   logic [7:0]  a8, b8, q8o, r8o;
   logic        busy8, out_en8, err8;

   seq_divider #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst32), .in_en(in_en32), .is_signed(sg32), .a(a32), .b(b32),
      .busy(busy32), .out_en(out_en32), .error(err32), .q(q32o), .r(r32o)
   );

   seq_divider #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst8), .in_en(in_en8), .is_signed(sg8), .a(a8), .b(b8),
      .busy(busy8), .out_en(out_en8), .error(err8), .q(q8o), .r(r8o)
   );

   typedef struct {
      logic [63:0] q;
      logic [63:0] r;
      bit          err;
      longint      cyc;
      int          blen;
   } exp_t;

   exp_t   sb32[$];
   exp_t   sb8[$];
   exp_t   e32, e8;
   longint cyc = 0;
   int     total = 0;
   int     passed = 0;
   int     brun32 = 0;
   int     brun8 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference: plain integer division on sign-extended 64-bit values.
   function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input bit s, input longint acc);
      exp_t        e;
      logic [63:0] mask;
      longint      sa, sb;
      mask = (64'd1 << w) - 64'd1;
      if (b == 64'd0) begin
         e.q   = mask;
         e.r   = a;
         e.err = 1'b1;
         e.blen = 1;
      end else begin
         if (s) begin
            sa  = $signed(a << (64 - w)) >>> (64 - w);
            sb  = $signed(b << (64 - w)) >>> (64 - w);
            e.q = 64'(sa / sb) & mask;
            e.r = 64'(sa % sb) & mask;
         end else begin
            e.q = a / b;
            e.r = a % b;
         end
         e.err  = 1'b0;
         e.blen = w + 1;
      end
      e.cyc = acc + e.blen;
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst32 !== 1'b0) brun32 = 0;
      else begin
         if (out_en32 === 1'b1) begin
            if (sb32.size() == 0) begin
               total++;
               $display("FAIL unexpected_out_en32: got out_en=1, expected no result");
            end else begin
               e32 = sb32.pop_front();
               check("q32", q32o, e32.q);
               check("r32", r32o, e32.r);
               check("err32", err32, e32.err);
               check("lat32", cyc, e32.cyc);
               check("busy_len32", brun32, e32.blen);
            end
            brun32 = 0;
         end
         if (busy32 === 1'b1) brun32++;
      end
   end

   always @(negedge clk) begin
      if (rst8 !== 1'b0) brun8 = 0;
      else begin
         if (out_en8 === 1'b1) begin
            if (sb8.size() == 0) begin
               total++;
               $display("FAIL unexpected_out_en8: got out_en=1, expected no result");
            end else begin
               e8 = sb8.pop_front();
               check("q8", q8o, e8.q);
               check("r8", r8o, e8.r);
               check("err8", err8, e8.err);
               check("lat8", cyc, e8.cyc);
               check("busy_len8", brun8, e8.blen);
            end
            brun8 = 0;
         end
         if (busy8 === 1'b1) brun8++;
      end
   end

   task automatic wait_idle32();
      int n = 0;
      while (busy32 !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         total++;
         $display("FAIL timeout_idle32: busy still %0b, expected 0", busy32);
      end
   endtask

   task automatic wait_idle8();
      int n = 0;
      while (busy8 !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         total++;
         $display("FAIL timeout_idle8: busy still %0b, expected 0", busy8);
      end
   endtask

   task automatic op32(input logic [31:0] a, input logic [31:0] b, input bit s, input bit expect_res);
      wait_idle32();
      a32 = a; b32 = b; sg32 = s; in_en32 = 1'b1;
      if (expect_res) sb32.push_back(model(32, 64'(a), 64'(b), s, cyc + 1));
      @(negedge clk);
      in_en32 = 1'b0;
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit s);
      wait_idle8();
      a8 = a; b8 = b; sg8 = s; in_en8 = 1'b1;
      sb8.push_back(model(8, 64'(a), 64'(b), s, cyc + 1));
      @(negedge clk);
      in_en8 = 1'b0;
   endtask

   function automatic logic [31:0] rand_div32();
      logic [31:0] v;
      case ($urandom_range(0, 9))
         0:       v = 32'd0;
         1, 2:    v = 32'($urandom_range(1, 300));
         3, 4:    v = -32'($urandom_range(1, 300));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      int n;
      rst32 = 1'b1; in_en32 = 1'b0; sg32 = 1'b0; a32 = '0; b32 = '0;
      rst8  = 1'b1; in_en8  = 1'b0; sg8  = 1'b0; a8  = '0; b8  = '0;
      repeat (3) @(negedge clk);
      rst32 = 1'b0; rst8 = 1'b0;

      check("reset_q32", q32o, 0);
      check("reset_r32", r32o, 0);
      check("reset_err32", err32, 0);
      check("reset_busy32", busy32, 0);
      check("reset_out_en32", out_en32, 0);
      check("reset_busy8", busy8, 0);

      // Directed cases: quadrants, divide by zero, overflow wrap
      op32(32'd100, 32'd7, 1'b0, 1'b1);
      op32(-32'sd7, 32'd2, 1'b1, 1'b1);
      op32(32'd7, -32'sd2, 1'b1, 1'b1);
      op32(-32'sd7, -32'sd2, 1'b1, 1'b1);
      op32(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
      op32(32'd55, 32'd0, 1'b0, 1'b1);
      op32(32'd55, 32'd0, 1'b1, 1'b1);
      op32(32'd9, 32'd4, 1'b0, 1'b1);
      op32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
      op32(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
      op32(32'h8000_0000, 32'd1, 1'b1, 1'b1);

      // in_en pulsed mid-operation with new operands must be ignored
      op32(32'd1000, 32'd33, 1'b0, 1'b1);
      repeat (9) @(negedge clk);
      a32 = 32'd77; b32 = 32'd0; sg32 = 1'b1; in_en32 = 1'b1;
      @(negedge clk);
      in_en32 = 1'b0;

      // in_en held through out_en: second op accepted with no idle gap
      wait_idle32();
      a32 = 32'd123456; b32 = 32'd789; sg32 = 1'b0; in_en32 = 1'b1;
      sb32.push_back(model(32, 64'(a32), 64'(b32), 1'b0, cyc + 1));
      @(negedge clk);
      n = 0;
      while (out_en32 !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         total++;
         $display("FAIL timeout_held_in_en: out_en %0b, expected 1", out_en32);
      end
      a32 = -32'sd5000; b32 = 32'd17; sg32 = 1'b1;
      sb32.push_back(model(32, 64'(a32), 64'(b32), 1'b1, cyc + 1));
      @(negedge clk);
      in_en32 = 1'b0;

      // Randomized traffic
      for (int i = 0; i < 30; i++)
         op32($urandom, rand_div32(), 1'($urandom_range(0, 1)), 1'b1);

      // Reset during iteration 15 aborts without a result
      op32(32'd99999, 32'd3, 1'b0, 1'b0);
      repeat (14) @(negedge clk);
      rst32 = 1'b1;
      @(negedge clk);
      rst32 = 1'b0;
      check("abort_q32", q32o, 0);
      check("abort_r32", r32o, 0);
      check("abort_err32", err32, 0);
      check("abort_busy32", busy32, 0);
      check("abort_out_en32", out_en32, 0);
      repeat (40) @(negedge clk);

      // rst and in_en together: nothing accepted
      a32 = 32'd10; b32 = 32'd3; in_en32 = 1'b1; rst32 = 1'b1;
      @(negedge clk);
      rst32 = 1'b0; in_en32 = 1'b0;
      check("rst_wins_busy32", busy32, 0);
      repeat (3) @(negedge clk);

      // A valid op after divide-by-zero clears error
      op32(32'd1, 32'd0, 1'b0, 1'b1);
      op32(32'd50, 32'd5, 1'b0, 1'b1);

      // WIDTH=8 instance
      op8(8'd200, 8'd13, 1'b0);
      op8(8'h80, 8'hFF, 1'b1);
      op8(8'd77, 8'd0, 1'b1);
      op8(8'hFF, 8'd1, 1'b0);
      for (int i = 0; i < 60; i++)
         op8(8'($urandom), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

      n = 0;
      while ((sb32.size() != 0 || sb8.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain32", sb32.size(), 0);
      check("drain8", sb8.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
